// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] ADJUST_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJUST_ADD       = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_FINISH  = 2'd2
    } state_e;

endpackage

// File: rtl/bin_to_bcd_seq_adjust.sv
// Combinational double-dabble digit cell: a digit of 5 or more gets 3 added before the shift.
module bcd_digit_adjust
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // A digit of at most 9 plus 3 stays below 16, so no carry leaves the digit.
    assign digit_o = (digit_i >= ADJUST_THRESHOLD) ? digit_i + ADJUST_ADD : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 converter: one shift per cycle, WIDTH+1 cycles per conversion,
// with registered digits and a display-overflow flag that only update on completion.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DIGITS      = 5,
    parameter int DISP_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          overflow
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e            state_q;
    logic [SR_W-1:0]   sr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;
    logic [BCD_W-1:0]  bcd_q;
    logic              ovf_q;

    logic [BCD_W-1:0]  bcd_adj;
    logic [SR_W-1:0]   sr_d;
    logic              ovf_d;

    // Upper field of the shift register holds the BCD digits, lower field the binary bits.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (sr_q[WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .digit_o (bcd_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end

    // The bit shifted out of the top digit is always zero when DIGITS is large enough.
    assign sr_d = SR_W'({bcd_adj, sr_q[WIDTH-1:0], 1'b0});

    if (DIGITS > DISP_DIGITS) begin : g_ovf
        assign ovf_d = |sr_q[SR_W-1 : WIDTH + BCD_DIGIT_W*DISP_DIGITS];
    end else begin : g_no_ovf
        assign ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sr_q    <= {{BCD_W{1'b0}}, bin_in};
                        cnt_q   <= '0;
                        state_q <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    bcd_q  <= sr_q[SR_W-1:WIDTH];
                    ovf_q  <= ovf_d;
                    done_q <= 1'b1;
                    // A start here is accepted immediately so back-to-back requests lose no cycle.
                    if (start) begin
                        sr_q    <= {{BCD_W{1'b0}}, bin_in};
                        cnt_q   <= '0;
                        state_q <= ST_CONVERT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state_q == ST_CONVERT) || (state_q == ST_FINISH);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed vector table, hand-written handshake sequences and
// random values against a decimal-arithmetic reference, on a 16-bit and an 8-bit instance.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, busy, done, overflow;
    logic [15:0] bin_in;
    logic [19:0] bcd_out;

    logic        reset8, start8, busy8, done8, ovf8;
    logic [7:0]  bin8;
    logic [11:0] bcd8;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .DISP_DIGITS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .DISP_DIGITS(4)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .bin_in(bin8),
        .busy(busy8), .done(done8), .bcd_out(bcd8), .overflow(ovf8)
    );

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by repeated division.
    function automatic logic [31:0] ref_bcd(input int unsigned v, input int nd);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or on timeout).
    task automatic conv16(input logic [15:0] v, input string tag,
                          output logic [19:0] got, output logic gov);
        logic [19:0] prev;
        int lat, busy_n;
        bit changed;
        prev = bcd_out; lat = 0; busy_n = 0; changed = 0;
        start = 1'b1; bin_in = v;
        @(negedge clk);
        start = 1'b0; bin_in = 16'($urandom);
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            if (bcd_out !== prev) changed = 1;
            @(negedge clk);
            lat++;
        end
        check($sformatf("%s latency", tag), lat, 17);
        check($sformatf("%s busy cycles", tag), busy_n, 17);
        check($sformatf("%s busy at done", tag), {31'd0, busy}, 0);
        check($sformatf("%s stable during convert", tag), {31'd0, changed}, 0);
        got = bcd_out; gov = overflow;
    endtask

    task automatic conv8(input logic [7:0] v, input string tag, output logic [11:0] got);
        int lat;
        lat = 0;
        start8 = 1'b1; bin8 = v;
        @(negedge clk);
        start8 = 1'b0; bin8 = 8'($urandom);
        while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("%s latency", tag), lat, 9);
        check($sformatf("%s overflow", tag), {31'd0, ovf8}, 0);
        got = bcd8;
    endtask

    initial begin
        vec_t        vecs[7];
        logic [19:0] got;
        logic [11:0] got8;
        logic        gov;
        int          n_done, k, idx;
        int          dk[$];
        logic [15:0] rv;
        logic [7:0]  rv8;

        vecs[0] = '{16'd0,     20'h00000, 1'b0};
        vecs[1] = '{16'd9999,  20'h09999, 1'b0};
        vecs[2] = '{16'd10000, 20'h10000, 1'b1};
        vecs[3] = '{16'd65535, 20'h65535, 1'b1};
        vecs[4] = '{16'd510,   20'h00510, 1'b0};
        vecs[5] = '{16'd1,     20'h00001, 1'b0};
        vecs[6] = '{16'd4095,  20'h04095, 1'b0};

        reset = 1'b1; start = 1'b0; bin_in = '0;
        reset8 = 1'b1; start8 = 1'b0; bin8 = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 0);
        check("reset done", {31'd0, done}, 0);
        check("reset bcd_out", {12'd0, bcd_out}, 0);
        check("reset overflow", {31'd0, overflow}, 0);
        // reset and start together: reset wins
        start = 1'b1; bin_in = 16'd5;
        @(negedge clk);
        check("reset beats start", {31'd0, busy}, 0);
        start = 1'b0; reset = 1'b0;

        foreach (vecs[i]) begin
            conv16(vecs[i].bin, $sformatf("vec%0d", i), got, gov);
            check($sformatf("vec%0d bcd", i), {12'd0, got}, {12'd0, vecs[i].bcd});
            check($sformatf("vec%0d ovf", i), {31'd0, gov}, {31'd0, vecs[i].ovf});
        end

        for (int i = 0; i < 20; i++) begin
            rv = 16'($urandom_range(0, 65535));
            conv16(rv, $sformatf("rnd%0d", i), got, gov);
            check($sformatf("rnd%0d bcd (%0d)", i, rv), {12'd0, got}, ref_bcd(rv, 5));
            check($sformatf("rnd%0d ovf (%0d)", i, rv), {31'd0, gov}, {31'd0, (rv >= 16'd10000)});
        end

        // start during CONVERT is ignored; bin_in changes have no effect
        start = 1'b1; bin_in = 16'd123;
        @(negedge clk);
        start = 1'b0; bin_in = 16'd999;
        repeat (4) @(negedge clk);
        start = 1'b1; bin_in = 16'd456;
        @(negedge clk);
        start = 1'b0; bin_in = 16'd0;
        n_done = 0; got = '0;
        for (int c = 0; c < 50; c++) begin
            if (done) begin
                n_done++;
                if (n_done == 1) got = bcd_out;
            end
            @(negedge clk);
        end
        check("ignored start done count", n_done, 1);
        check("ignored start bcd", {12'd0, got}, 32'h00123);

        // reset mid-conversion aborts without a done pulse
        start = 1'b1; bin_in = 16'd777;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 0);
        check("abort bcd_out", {12'd0, bcd_out}, 0);
        check("abort done", {31'd0, done}, 0);
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("abort no done", n_done, 0);
        conv16(16'd777, "after abort", got, gov);
        check("after abort bcd", {12'd0, got}, ref_bcd(777, 5));

        // start held high: back-to-back every WIDTH+1 cycles
        start = 1'b1; bin_in = 16'd42;
        @(negedge clk);
        k = 0;
        while (dk.size() < 3 && k < 200) begin
            if (done) begin
                dk.push_back(k);
                check($sformatf("b2b bcd %0d", dk.size()), {12'd0, bcd_out}, 32'h00042);
            end
            @(negedge clk);
            k++;
        end
        check("b2b done count", dk.size(), 3);
        for (int i = 0; i < dk.size(); i++) begin
            check($sformatf("b2b done cycle %0d", i), dk[i], 17 * (i + 1));
        end
        start = 1'b0;
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("b2b drains to idle", {31'd0, busy}, 0);

        // 8-bit instance
        reset8 = 1'b0;
        @(negedge clk);
        conv8(8'd255, "w8 255", got8);
        check("w8 255 bcd", {20'd0, got8}, 32'h255);
        for (int i = 0; i < 6; i++) begin
            rv8 = 8'($urandom_range(0, 255));
            idx = i;
            conv8(rv8, $sformatf("w8 rnd%0d", idx), got8);
            check($sformatf("w8 rnd%0d bcd (%0d)", idx, rv8), {20'd0, got8}, ref_bcd(rv8, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
